// File: rtl/branch_resolve_queue.sv
// In-order queue of branch predictions that pairs each one with its resolved outcome and drives predictor training.
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    output logic             pred_ready_o,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    output logic             upd_valid_o,
    output logic             upd_taken_o,
    output logic             mispredict_o,
    output logic [PTR_W:0]   occupancy_o,
    output logic             err_orphan_o,
    output logic [CNT_W-1:0] resolved_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    logic [DEPTH-1:0] entry_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic             upd_valid_q, upd_taken_q, mispredict_q, err_orphan_q;
    logic             upd_taken_d, err_orphan_d;
    logic             full, push, pop, miss, orphan;

    assign full   = (occ_q == (PTR_W+1)'(DEPTH));
    assign push   = pred_valid_i & ~full;
    assign pop    = res_valid_i & (occ_q != '0);
    assign miss   = pop & (entry_q[rd_ptr_q] != res_taken_i);
    assign orphan = res_valid_i & (occ_q == '0);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        upd_taken_d  = upd_taken_q;
        err_orphan_d = err_orphan_q | orphan;
        if (pop) begin
            upd_taken_d = res_taken_i;
        end
        if (miss) begin
            // a mispredict squashes every younger entry, including one arriving this cycle
            rd_ptr_d = wr_ptr_q;
            occ_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            occ_d    = occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            upd_valid_q  <= 1'b0;
            upd_taken_q  <= 1'b0;
            mispredict_q <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            upd_valid_q  <= pop;
            upd_taken_q  <= upd_taken_d;
            mispredict_q <= miss;
            err_orphan_q <= err_orphan_d;
        end
    end

    // storage is intentionally not reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (push && !miss) begin
            entry_q[wr_ptr_q] <= pred_taken_i;
        end
    end

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] resolved_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolved_cnt_q <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            if (pop && (resolved_cnt_q != '1)) begin
                resolved_cnt_q <= resolved_cnt_q + 1'b1;
            end
            if (miss && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign resolved_cnt_o = resolved_cnt_q;
    assign mispred_cnt_o  = mispred_cnt_q;
`else
    assign resolved_cnt_o = '0;
    assign mispred_cnt_o  = '0;
`endif

    assign pred_ready_o = ~full;
    assign upd_valid_o  = upd_valid_q;
    assign upd_taken_o  = upd_taken_q;
    assign mispredict_o = mispredict_q;
    assign occupancy_o  = occ_q;
    assign err_orphan_o = err_orphan_q;

endmodule
